// File: rtl/pe_cfg_loader.sv
// Configuration loader: parses header/payload packets from a valid/ready
// stream and replays each payload word as a one-cycle {1'b1, word} beat on
// the addressed PE's configuration port.
module pe_cfg_loader #(
  parameter int unsigned NUM_PE = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_in_valid,
  input  logic [31:0]           cfg_in_data,
  output logic                  cfg_in_ready,
  output logic [NUM_PE*33-1:0]  pe_cfg_out,
  output logic                  busy,
  output logic                  pkt_done,
  output logic                  cfg_err,
  output logic [7:0]            pkt_count
);

  typedef enum logic [1:0] {StIdle, StLoad, StDrop} state_e;

  localparam logic [4:0] NumPeW = 5'(NUM_PE);

  state_e                state_q, state_d;
  logic [3:0]            id_q, id_d;
  logic [7:0]            rem_q, rem_d;
  logic [NUM_PE*33-1:0]  out_q, out_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [7:0]            cnt_q, cnt_d;

  logic       xfer;
  logic [3:0] hdr_id;
  logic [7:0] hdr_len;
  logic       hdr_id_ok;

  // The loader never stalls: it is ready whenever it is out of reset.
  assign cfg_in_ready = reset;
  assign xfer         = cfg_in_valid & cfg_in_ready;
  assign hdr_id       = cfg_in_data[31:28];
  assign hdr_len      = cfg_in_data[23:16];
  assign hdr_id_ok    = {1'b0, hdr_id} < NumPeW;

  // Next-state: header parsing in idle, payload counting in load/drop.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    rem_d   = rem_q;
    out_d   = '0;
    done_d  = 1'b0;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (xfer) begin
          id_d  = hdr_id;
          rem_d = hdr_len;
          if (!hdr_id_ok) err_d = 1'b1;
          if (hdr_len == 8'd0) begin
            // Empty packet completes immediately without leaving idle.
            done_d = 1'b1;
            cnt_d  = cnt_q + 8'd1;
          end else begin
            state_d = hdr_id_ok ? StLoad : StDrop;
          end
        end
      end
      StLoad, StDrop: begin
        if (xfer) begin
          if (state_q == StLoad) begin
            for (int unsigned i = 0; i < NUM_PE; i++) begin
              if (id_q == 4'(i)) out_d[33*i +: 33] = {1'b1, cfg_in_data};
            end
          end
          rem_d = rem_q - 8'd1;
          if (rem_q == 8'd1) begin
            state_d = StIdle;
            done_d  = 1'b1;
            cnt_d   = cnt_q + 8'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      id_q    <= '0;
      rem_q   <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      rem_q   <= rem_d;
      out_q   <= out_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pe_cfg_out = out_q;
  assign busy       = (state_q != StIdle);
  assign pkt_done   = done_q;
  assign cfg_err    = err_q;
  assign pkt_count  = cnt_q;

endmodule

// File: tb/tb_pe_cfg_loader.sv
// Self-checking bench for pe_cfg_loader: directed packet scenarios with
// literal expectations plus a long randomized run against a packet-level model.
module tb_pe_cfg_loader;

  localparam int unsigned NP = 2;
  localparam int unsigned W  = NP * 33;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cfg_in_valid = 1'b0;
  logic [31:0]   cfg_in_data = '0;
  logic          cfg_in_ready;
  logic [W-1:0]  pe_cfg_out;
  logic          busy;
  logic          pkt_done;
  logic          cfg_err;
  logic [7:0]    pkt_count;

  pe_cfg_loader #(.NUM_PE(NP)) dut (
    .clk          (clk),
    .reset        (reset),
    .cfg_in_valid (cfg_in_valid),
    .cfg_in_data  (cfg_in_data),
    .cfg_in_ready (cfg_in_ready),
    .pe_cfg_out   (pe_cfg_out),
    .busy         (busy),
    .pkt_done     (pkt_done),
    .cfg_err      (cfg_err),
    .pkt_count    (pkt_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Packet-level model: words left in the current packet, its target, and
  // the observable results of the most recent clock edge.
  bit           live = 1'b0;
  int           rem = 0;
  int           tgt = 0;
  logic [W-1:0] m_out = '0;
  bit           m_done = 1'b0;
  bit           m_err = 1'b0;
  logic [7:0]   m_cnt = '0;

  always @(posedge clk) begin : model
    int r, t, n;
    logic [W-1:0] o;
    bit dn, e;
    logic [7:0] c;
    if (!reset) begin
      live   <= 1'b1;
      rem    <= 0;
      tgt    <= 0;
      m_out  <= '0;
      m_done <= 1'b0;
      m_err  <= 1'b0;
      m_cnt  <= '0;
    end else begin
      r = rem; t = tgt; o = '0; dn = 1'b0; e = m_err; c = m_cnt;
      if (cfg_in_valid) begin
        if (r == 0) begin
          t = int'(cfg_in_data[31:28]);
          n = int'(cfg_in_data[23:16]);
          if (t >= NP) e = 1'b1;
          if (n == 0) begin dn = 1'b1; c = c + 8'd1; end
          else r = n;
        end else begin
          if (t < NP) o[33*t +: 33] = {1'b1, cfg_in_data};
          r = r - 1;
          if (r == 0) begin dn = 1'b1; c = c + 8'd1; end
        end
      end
      rem <= r; tgt <= t; m_out <= o; m_done <= dn; m_err <= e; m_cnt <= c;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (live) begin
      check("out",   66'(pe_cfg_out),   66'(m_out));
      check("busy",  66'(busy),         66'(rem != 0));
      check("done",  66'(pkt_done),     66'(m_done));
      check("err",   66'(cfg_err),      66'(m_err));
      check("count", 66'(pkt_count),    66'(m_cnt));
      check("ready", 66'(cfg_in_ready), 66'(reset));
    end
  end

  task automatic drive(input bit v, input logic [31:0] d, input bit r);
    cfg_in_valid = v;
    cfg_in_data  = d;
    reset        = r;
    @(posedge clk);
    #1;
  endtask

  task automatic rst1();
    drive(1'b0, 32'd0, 1'b0);
  endtask

  // Header with randomized reserved bits.
  function automatic logic [31:0] hdr(input int id, input int n);
    return ($urandom & 32'h0F00_FFFF) | {4'(id), 4'h0, 8'(n), 16'h0};
  endfunction

  function automatic logic [65:0] sl(input int i, input logic [31:0] w);
    logic [W-1:0] v;
    v = '0;
    v[33*i +: 33] = {1'b1, w};
    return 66'(v);
  endfunction

  initial begin
    #1;
    // Reset state
    drive(1'b0, 32'd0, 1'b0);
    drive(1'b0, 32'd0, 1'b0);
    check("rst_out",   66'(pe_cfg_out),   66'd0);
    check("rst_ready", 66'(cfg_in_ready), 66'd0);
    check("rst_busy",  66'(busy),         66'd0);
    check("rst_count", 66'(pkt_count),    66'd0);
    drive(1'b0, 32'd0, 1'b1);

    // Two-PE back-to-back load
    drive(1'b1, hdr(0, 2), 1'b1);
    check("tp_busy", 66'(busy), 66'd1);
    drive(1'b1, 32'h0A5B2C98, 1'b1);
    check("tp_s0_w0", 66'(pe_cfg_out), sl(0, 32'h0A5B2C98));
    drive(1'b1, 32'd0, 1'b1);
    check("tp_s0_w1", 66'(pe_cfg_out), sl(0, 32'd0));
    check("tp_done0", 66'(pkt_done), 66'd1);
    drive(1'b1, hdr(1, 2), 1'b1);
    check("tp_hdr_out", 66'(pe_cfg_out), 66'd0);
    check("tp_hdr_done", 66'(pkt_done), 66'd0);
    drive(1'b1, 32'd2, 1'b1);
    check("tp_s1_w0", 66'(pe_cfg_out), sl(1, 32'd2));
    drive(1'b1, 32'd0, 1'b1);
    check("tp_s1_w1", 66'(pe_cfg_out), sl(1, 32'd0));
    check("tp_done1", 66'(pkt_done), 66'd1);
    check("tp_count", 66'(pkt_count), 66'd2);
    drive(1'b0, 32'd0, 1'b1);

    // Valid gaps
    rst1();
    drive(1'b1, hdr(1, 3), 1'b1);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'(5 + k), 1'b1);
      check("gap_beat", 66'(pe_cfg_out), sl(1, 32'(5 + k)));
      check("gap_busy_beat", 66'(busy), (k == 2) ? 66'd0 : 66'd1);
      if (k < 2) begin
        for (int j = 0; j < 2; j++) begin
          drive(1'b0, $urandom, 1'b1);
          check("gap_idle_out", 66'(pe_cfg_out), 66'd0);
          check("gap_idle_busy", 66'(busy), 66'd1);
        end
      end
    end

    // Bad target then a good packet
    rst1();
    drive(1'b1, hdr(5, 2), 1'b1);
    check("bad_err", 66'(cfg_err), 66'd1);
    check("bad_busy", 66'(busy), 66'd1);
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, $urandom, 1'b1);
      check("bad_drop_out", 66'(pe_cfg_out), 66'd0);
    end
    drive(1'b1, hdr(0, 1), 1'b1);
    drive(1'b1, 32'hFFFF_FFFF, 1'b1);
    check("bad_good_beat", 66'(pe_cfg_out), sl(0, 32'hFFFF_FFFF));
    check("bad_count", 66'(pkt_count), 66'd2);
    check("bad_err_sticky", 66'(cfg_err), 66'd1);

    // Zero-length packet followed immediately by a real one
    rst1();
    drive(1'b1, hdr(0, 0), 1'b1);
    check("zl_done", 66'(pkt_done), 66'd1);
    check("zl_out", 66'(pe_cfg_out), 66'd0);
    check("zl_busy", 66'(busy), 66'd0);
    check("zl_count", 66'(pkt_count), 66'd1);
    drive(1'b1, hdr(0, 1), 1'b1);
    check("zl_hdr2_busy", 66'(busy), 66'd1);
    check("zl_hdr2_done", 66'(pkt_done), 66'd0);
    drive(1'b1, 32'd9, 1'b1);
    check("zl_beat", 66'(pe_cfg_out), sl(0, 32'd9));
    check("zl_done2", 66'(pkt_done), 66'd1);

    // Reset mid-packet
    rst1();
    drive(1'b1, hdr(0, 4), 1'b1);
    drive(1'b1, $urandom, 1'b1);
    drive(1'b1, $urandom, 1'b1);
    drive(1'b1, $urandom, 1'b0);
    check("rm_out", 66'(pe_cfg_out), 66'd0);
    check("rm_busy", 66'(busy), 66'd0);
    check("rm_done", 66'(pkt_done), 66'd0);
    check("rm_count", 66'(pkt_count), 66'd0);
    check("rm_ready", 66'(cfg_in_ready), 66'd0);
    drive(1'b1, hdr(1, 1), 1'b1);
    check("rm_hdr_done", 66'(pkt_done), 66'd0);
    drive(1'b1, 32'd3, 1'b1);
    check("rm_beat", 66'(pe_cfg_out), sl(1, 32'd3));
    check("rm_count2", 66'(pkt_count), 66'd1);

    // Counter wrap
    rst1();
    for (int k = 0; k < 256; k++) drive(1'b1, hdr($urandom_range(0, 1), 0), 1'b1);
    check("wrap_count", 66'(pkt_count), 66'd0);
    check("wrap_err", 66'(cfg_err), 66'd0);
    check("wrap_done", 66'(pkt_done), 66'd1);

    // Randomized traffic with short packets, bad IDs, gaps and rare resets
    rst1();
    for (int k = 0; k < 4000; k++) begin
      logic [31:0] d;
      bit v, r;
      r = ($urandom_range(0, 199) != 0);
      v = ($urandom_range(0, 9) < 7);
      d = $urandom;
      if ($urandom_range(0, 1) == 1) d[23:19] = 5'd0;
      if ($urandom_range(0, 1) == 1) d[31:29] = 3'd0;
      drive(v, d, r);
    end
    drive(1'b0, 32'd0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
